// File: rtl/full_adder_behavioural.sv
// full_adder_behavioural: WIDTH-bit adder with carry-in, offering a
// combinational result and a one-cycle registered result with valid.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   a, b          WIDTH-bit operands
//   carry_in      carry into bit 0
//   in_valid      qualifies a/b/carry_in for the registered path
//   sum           combinational (a + b + carry_in) mod 2^WIDTH
//   carry_out     combinational carry out of the MSB
//   ovf           combinational signed overflow (0 when WIDTH=1)
//   sum_q         registered sum
//   carry_out_q   registered carry_out
//   ovf_q         registered ovf
//   out_valid     registered outputs hold a fresh result
//   check_err     sticky mismatch flag of the reference chain
//
// Build option: FULL_ADDER_SELFCHECK_EN adds a gate-level ripple chain
// checked against the behavioural add; otherwise check_err is tied low.

module full_adder_behavioural #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             ovf_q,
    output logic             out_valid,
    output logic             check_err
);

    // Behavioural add at WIDTH+1 bits so the carry is never lost.
    logic [WIDTH:0] full_w;

    assign full_w    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign sum       = full_w[WIDTH-1:0];
    assign carry_out = full_w[WIDTH];

    // Carry into the MSB is recovered from the MSB sum bit.
    generate
        if (WIDTH == 1) begin : g_ovf_1b
            assign ovf = 1'b0;
        end else begin : g_ovf_nb
            assign ovf = sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1]
                       ^ carry_out;
        end
    endgenerate

    // Registered result path.
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;
    logic             ovf_d;
    logic             out_valid_d;

    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum;
            carry_out_d = carry_out;
            ovf_d       = ovf;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
            out_valid   <= out_valid_d;
        end
    end

`ifdef FULL_ADDER_SELFCHECK_EN
    // Explicit per-bit ripple chain used as an independent reference.
    logic [WIDTH-1:0] ref_sum;
    logic             ref_cout;
    logic             rc;
    logic             mismatch;
    logic             check_err_q;
    logic             check_err_d;

    always_comb begin
        rc      = carry_in;
        ref_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ref_sum[i] = a[i] ^ b[i] ^ rc;
            rc         = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
        end
        ref_cout = rc;
    end

    assign mismatch    = ({ref_cout, ref_sum} != {carry_out, sum});
    assign check_err_d = check_err_q | mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            check_err_q <= 1'b0;
        end else begin
            check_err_q <= check_err_d;
        end
    end

    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_behavioural.sv
// tb_full_adder_behavioural: scoreboard bench for full_adder_behavioural
// at WIDTH=1, 4 and 8.

module tb_full_adder_behavioural;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=1 instance
    logic [0:0] a1, b1, s1, sq1;
    logic c1, iv1, co1, ov1, coq1, ovq1, vq1, ce1;

    full_adder_behavioural #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(c1),
        .in_valid(iv1), .sum(s1), .carry_out(co1), .ovf(ov1),
        .sum_q(sq1), .carry_out_q(coq1), .ovf_q(ovq1),
        .out_valid(vq1), .check_err(ce1)
    );

    // WIDTH=4 instance
    logic [3:0] a4, b4, s4, sq4;
    logic c4, iv4, co4, ov4, coq4, ovq4, vq4, ce4;

    full_adder_behavioural #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .carry_in(c4),
        .in_valid(iv4), .sum(s4), .carry_out(co4), .ovf(ov4),
        .sum_q(sq4), .carry_out_q(coq4), .ovf_q(ovq4),
        .out_valid(vq4), .check_err(ce4)
    );

    // WIDTH=8 instance
    logic [7:0] a8, b8, s8, sq8;
    logic c8, iv8, co8, ov8, coq8, ovq8, vq8, ce8;

    full_adder_behavioural #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .carry_in(c8),
        .in_valid(iv8), .sum(s8), .carry_out(co8), .ovf(ov8),
        .sum_q(sq8), .carry_out_q(coq8), .ovf_q(ovq8),
        .out_valid(vq8), .check_err(ce8)
    );

    // Scoreboard for the WIDTH=8 registered path: {ovf, cout, sum}.
    logic [9:0] sb_q[$];
    logic       mon_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (mon_en && vq8) begin
            if (sb_q.size() == 0) begin
                chk("sb8_empty", 1, 0);
            end else begin
                chk("sb8", {ovq8, coq8, sq8}, sb_q.pop_front());
            end
        end
    end

    function automatic logic [9:0] model8(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic ci);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    logic [1:0] tbl1 [8];
    logic [9:0] e8;

    initial begin
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        a1 = '0; b1 = '0; c1 = 0; iv1 = 0;
        a4 = '0; b4 = '0; c4 = 0; iv4 = 0;
        a8 = '0; b8 = '0; c8 = 0; iv8 = 0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_q1", {sq1, coq1, ovq1, vq1, ce1}, 0);
        chk("rst_q4", {sq4, coq4, ovq4, vq4, ce4}, 0);
        chk("rst_q8", {sq8, coq8, ovq8, vq8, ce8}, 0);

        // WIDTH=1 truth table, combinational
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #1;
            chk($sformatf("w1_%0d", i), {co1, s1}, tbl1[i]);
            chk($sformatf("w1_ovf_%0d", i), ov1, 0);
        end

        // WIDTH=4 combinational boundaries
        a4 = 4'hF; b4 = 4'h1; c4 = 0;
        #1;
        chk("w4_wrap", {ov4, co4, s4}, {1'b0, 1'b1, 4'h0});
        a4 = 4'h7; b4 = 4'h1; c4 = 0;
        #1;
        chk("w4_ovf", {ov4, co4, s4}, {1'b1, 1'b0, 4'h8});

        // Registered latency and hold
        rst = 1'b0;
        tick();
        a4 = 4'd3; b4 = 4'd4; c4 = 1; iv4 = 1;
        tick();
        chk("lat_sum", sq4, 4'h8);
        chk("lat_vld", vq4, 1);
        chk("lat_flags", {ovq4, coq4}, 2'b10);
        iv4 = 0; a4 = 4'd1; b4 = 4'd1; c4 = 0;
        tick();
        chk("hold_vld", vq4, 0);
        chk("hold_sum", {ovq4, coq4, sq4}, {1'b1, 1'b0, 4'h8});

        // Reset mid-stream
        a4 = 4'd5; b4 = 4'd6; c4 = 0; iv4 = 1; rst = 1'b1;
        #1;
        chk("rst_comb", s4, 4'hB);
        tick();
        chk("rst_mid", {sq4, coq4, ovq4, vq4}, 0);
        a4 = 4'd9; b4 = 4'd9; c4 = 1;
        #1;
        chk("rst_comb2", {co4, s4}, 5'h13);

        // Capture on first edge after reset falls
        rst = 1'b0; a4 = 4'd2; b4 = 4'd2; c4 = 0; iv4 = 1;
        tick();
        chk("post_rst", {vq4, sq4}, {1'b1, 4'h4});
        iv4 = 0;

        // Random WIDTH=8 stream through the scoreboard
        mon_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            iv8 = ($urandom_range(0, 3) != 0);
            e8  = model8(a8, b8, c8);
            if (iv8) sb_q.push_back(e8);
            #1;
            chk("comb8", {ov8, co8, s8}, e8);
            #4;
            @(posedge clk);
            #1;
        end
        iv8 = 0;
        tick();
        tick();
        tick();
        mon_en = 1'b0;
        chk("sb8_drain", sb_q.size(), 0);
        chk("chk_err8", ce8, 0);
        chk("chk_err4", ce4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
